// File: rtl/axi_burst_reader.sv
// axi_burst_reader: AXI4 read master that splits one (address, beat-count) command into boundary-aligned INCR bursts and streams the beats out through a FIFO
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmd_valid/ready/addr/len command handshake, byte start address, beat count (0 allowed)
//   m_axi_ar*                AXI4 read address channel (single ID, INCR, full-width beats)
//   m_axi_r*                 AXI4 read data channel, never back-pressured outside reset
//   out_valid/ready/data     output beat stream; out_last marks the final beat of a command
//   done                     one-cycle pulse when a command has fully completed
//   error                    sticky rresp / rlast error, cleared on the next command acceptance
module axi_burst_reader #(
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int AR_ID         = 0,
    parameter int MAX_BURST_LEN = 64,
    parameter int FIFO_DEPTH    = 128,
    parameter int LEN_WIDTH     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done,
    output logic                  error
);
    localparam int SZ = $clog2(DATA_WIDTH / 8);
    localparam int LB = $clog2(MAX_BURST_LEN);
    localparam int BW = LB + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] MAX_C   = BW'(MAX_BURST_LEN);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_n;

    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining, out_rem, r_rem;
    logic [LB-1:0]         r_ofs;
    logic [CW-1:0]         outstanding, count;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [BW-1:0]         to_bnd, blen;
    logic [8:0]            ar_beats;
    logic                  last_seen, cmd_fire, ar_fire, r_fire, out_fire, can_issue, finish;

    assign m_axi_arid    = ID_WIDTH'(AR_ID);
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;
    assign m_axi_rready  = !rst;
    assign cmd_ready     = !rst && state == IDLE;
    assign out_valid     = count != '0;
    assign out_data      = mem[rd_ptr];
    assign out_last      = out_valid && out_rem == LEN_WIDTH'(1);

    assign cmd_fire = cmd_valid && cmd_ready;
    assign ar_fire  = m_axi_arvalid && m_axi_arready;
    assign r_fire   = m_axi_rvalid && m_axi_rready;
    assign out_fire = out_valid && out_ready;
    assign ar_beats = {1'b0, m_axi_arlen} + 9'd1;

    // Beats left before the next MAX_BURST_LEN-aligned boundary caps the burst.
    assign to_bnd = MAX_C - BW'(addr[SZ +: LB]);
    assign blen   = remaining < LEN_WIDTH'(to_bnd) ? BW'(remaining) : to_bnd;

    // Credit: every beat already in the FIFO or still owed by the slave holds a slot,
    // so a burst is requested only when all of its beats are guaranteed a place.
    assign can_issue = state == ISSUE && !m_axi_arvalid && DEPTH_C - (count + outstanding) >= CW'(blen);
    assign finish    = state == DRAIN && outstanding == '0 && (last_seen || (out_fire && out_last));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_fire && cmd_len != '0) state_n = ISSUE;
            ISSUE:   if (ar_fire && remaining == LEN_WIDTH'(ar_beats)) state_n = DRAIN;
            DRAIN:   if (finish) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            out_rem       <= '0;
            r_rem         <= '0;
            r_ofs         <= '0;
            outstanding   <= '0;
            count         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            last_seen     <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state       <= state_n;
            done        <= finish || (cmd_fire && cmd_len == '0);
            outstanding <= outstanding + (ar_fire ? CW'(ar_beats) : '0) - CW'(r_fire);
            count       <= count + CW'(r_fire) - CW'(out_fire);
            if (r_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
                r_ofs  <= r_ofs + LB'(1);
                r_rem  <= r_rem - LEN_WIDTH'(1);
                // A burst ends either at the command's last beat or at an aligned boundary.
                if (m_axi_rresp != 2'b00 || m_axi_rlast != (r_rem == LEN_WIDTH'(1) || &r_ofs))
                    error <= 1'b1;
            end
            if (out_fire) begin
                rd_ptr  <= rd_ptr + AW'(1);
                out_rem <= out_rem - LEN_WIDTH'(1);
                if (out_last) last_seen <= 1'b1;
            end
            if (ar_fire) begin
                m_axi_arvalid <= 1'b0;
                addr          <= addr + (ADDR_WIDTH'(ar_beats) << SZ);
                remaining     <= remaining - LEN_WIDTH'(ar_beats);
            end else if (can_issue) begin
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= addr;
                m_axi_arlen   <= 8'(blen - BW'(1));
            end
            if (cmd_fire) begin
                addr      <= (cmd_addr >> SZ) << SZ;
                remaining <= cmd_len;
                out_rem   <= cmd_len;
                r_rem     <= cmd_len;
                r_ofs     <= cmd_addr[SZ +: LB];
                last_seen <= 1'b0;
                error     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) if (r_fire) mem[wr_ptr] <= m_axi_rdata;
endmodule

// File: tb/tb_axi_burst_reader.sv
// tb_axi_burst_reader: scoreboard bench with a behavioural AXI4 read slave for axi_burst_reader
module tb_axi_burst_reader;
    logic         clk = 1'b0, rst = 1'b1;
    logic         cmd_valid = 1'b0, cmd_ready;
    logic [31:0]  cmd_addr = '0;
    logic [19:0]  cmd_len = '0;
    logic [7:0]   m_axi_arid, m_axi_arlen;
    logic [31:0]  m_axi_araddr;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst, m_axi_rresp;
    logic         m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [511:0] m_axi_rdata, out_data;
    logic         out_last, out_valid, done, error;
    logic         out_ready = 1'b1;

    typedef struct packed {logic [31:0] addr; logic [7:0] len;} ar_t;
    typedef struct {logic [511:0] d; bit last;} exp_t;
    ar_t  bq[$];
    ar_t  arlog[$];
    exp_t exp_q[$];
    int   r_idx = 0, r_total = 0, err_at = -1;
    bit   slv_rand = 1'b0;
    int   vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    axi_burst_reader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .error(error)
    );

    function automatic logic [511:0] data_of(input logic [31:0] beat);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = beat * 32'h9E3779B1 + 32'(k) * 32'h01000193;
        return d;
    endfunction

    // Memory slave: in-order bursts, optional AR stalls and R gaps, programmable error beat.
    always @(posedge clk) begin
        if (rst) begin
            bq.delete();
            r_idx         <= 0;
            m_axi_arready <= 1'b0;
            m_axi_rvalid  <= 1'b0;
            m_axi_rlast   <= 1'b0;
            m_axi_rresp   <= 2'b00;
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                bq.push_back({m_axi_araddr, m_axi_arlen});
                arlog.push_back({m_axi_araddr, m_axi_arlen});
            end
            m_axi_arready <= slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bq.size() != 0 && (!slv_rand || $urandom_range(0, 3) != 0)) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= data_of((bq[0].addr >> 6) + 32'(r_idx));
                m_axi_rlast  <= r_idx == int'(bq[0].len);
                m_axi_rresp  <= r_total == err_at ? 2'b10 : 2'b00;
                r_total      <= r_total + 1;
                if (r_idx == int'(bq[0].len)) begin
                    bq.pop_front();
                    r_idx <= 0;
                end else r_idx <= r_idx + 1;
            end else m_axi_rvalid <= 1'b0;
        end
    end

    task automatic send_cmd(input logic [31:0] a, input int n);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = 20'(n);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
        end
        for (int i = 0; i < n; i++) exp_q.push_back('{data_of((a >> 6) + 32'(i)), i == n - 1});
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic consume(input bit rnd, input int budget);
        int   t = 0;
        bit   early = 1'b0;
        exp_t e;
        while (t < budget) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            early |= done === 1'b1;
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat: data=%h required no beat", out_data[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_last !== e.last) begin
                        miscompares++;
                        $display("FAIL beat: data=%h last=%b required data=%h last=%b", out_data[63:0], out_last, e.d[63:0], e.last);
                    end
                end
                if (out_last === 1'b1) begin
                    @(negedge clk);
                    vectors++;
                    if (done !== 1'b1 || cmd_ready !== 1'b1 || early || exp_q.size() != 0) begin
                        miscompares++;
                        $display("FAIL done: done=%b cmd_ready=%b early=%b left=%0d required 1 1 0 0", done, cmd_ready, early, exp_q.size());
                    end
                    exp_q.delete();
                    return;
                end
            end
            @(negedge clk);
            t++;
        end
        vectors++;
        miscompares++;
        $display("FAIL consume_timeout: %0d beats outstanding required 0", exp_q.size());
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b0 || m_axi_rready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hold: cmd_ready=%b rready=%b required 0 0", cmd_ready, m_axi_rready);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cmd_ready, m_axi_arvalid, m_axi_rready, out_valid, out_last, done, error} !== 7'b1010000) begin
            miscompares++;
            $display("FAIL rst_ctl: got %b required 1010000", {cmd_ready, m_axi_arvalid, m_axi_rready, out_valid, out_last, done, error});
        end
        vectors++;
        if (m_axi_araddr !== 32'h0 || m_axi_arlen !== 8'h0) begin
            miscompares++;
            $display("FAIL rst_ar: araddr=%h arlen=%h required 0 0", m_axi_araddr, m_axi_arlen);
        end
        vectors++;
        if (m_axi_arid !== 8'h0 || m_axi_arsize !== 3'd6 || m_axi_arburst !== 2'b01) begin
            miscompares++;
            $display("FAIL ar_const: id=%h size=%0d burst=%b required 0 6 01", m_axi_arid, m_axi_arsize, m_axi_arburst);
        end
    endtask

    task automatic test_single();
        int base = arlog.size();
        send_cmd(32'h1000, 4);
        consume(1'b0, 200);
        vectors++;
        if (arlog.size() != base + 1 || arlog[base] !== {32'h1000, 8'd3} || error !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ar: ars=%0d first=%h error=%b required 1 0000100003 0", arlog.size() - base, arlog[base], error);
        end
    endtask

    task automatic test_boundary();
        int base = arlog.size();
        slv_rand = 1'b1;
        send_cmd(32'h0FC0, 100);
        consume(1'b1, 3000);
        slv_rand = 1'b0;
        vectors++;
        if (arlog.size() != base + 3) begin
            miscompares++;
            $display("FAIL boundary_count: ars=%0d required 3", arlog.size() - base);
        end else begin
            vectors++;
            if (arlog[base] !== {32'h0FC0, 8'd0} || arlog[base+1] !== {32'h1000, 8'd63} || arlog[base+2] !== {32'h2000, 8'd34}) begin
                miscompares++;
                $display("FAIL boundary_ars: %h %h %h required 00000fc000 000010003f 0000200022", arlog[base], arlog[base+1], arlog[base+2]);
            end
        end
    endtask

    task automatic test_credit();
        int          base = arlog.size();
        int          sum = 0;
        bit          ok = 1'b1;
        logic [31:0] na = 32'h10000;
        out_ready = 1'b0;
        send_cmd(32'h10000, 300);
        repeat (400) @(negedge clk);
        vectors++;
        if (arlog.size() != base + 2 || m_axi_arvalid !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL credit_stall: ars=%0d arvalid=%b out_valid=%b required 2 0 1", arlog.size() - base, m_axi_arvalid, out_valid);
        end
        consume(1'b1, 6000);
        for (int i = base; i < arlog.size(); i++) begin
            if (arlog[i].addr !== na || arlog[i].len !== (i == base + 4 ? 8'd43 : 8'd63)) ok = 1'b0;
            na  += (32'(arlog[i].len) + 1) << 6;
            sum += int'(arlog[i].len) + 1;
        end
        vectors++;
        if (!ok || sum != 300 || arlog.size() != base + 5) begin
            miscompares++;
            $display("FAIL credit_ars: ars=%0d beats=%0d order_ok=%b required 5 300 1", arlog.size() - base, sum, ok);
        end
    endtask

    task automatic test_error();
        err_at = r_total + 1;
        send_cmd(32'h2000, 4);
        consume(1'b0, 200);
        err_at = -1;
        repeat (5) @(negedge clk);
        vectors++;
        if (error !== 1'b1) begin
            miscompares++;
            $display("FAIL error_sticky: error=%b required 1", error);
        end
        send_cmd(32'h0, 0);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL error_clear: error=%b required 0", error);
        end
    endtask

    task automatic test_zero_len();
        int base = arlog.size();
        send_cmd(32'h5000, 0);
        vectors++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_done: done=%b cmd_ready=%b required 1 1", done, cmd_ready);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pulse: done=%b required 0", done);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (arlog.size() != base || m_axi_arvalid !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_no_ar: ars=%0d arvalid=%b out_valid=%b required 0 0 0", arlog.size() - base, m_axi_arvalid, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int base = arlog.size();
        int t = 0;
        out_ready = 1'b0;
        send_cmd(32'h40000, 300);
        while (arlog.size() < base + 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (arlog.size() < base + 2) begin
            miscompares++;
            $display("FAIL midrst_setup: ars=%0d required 2", arlog.size() - base);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({m_axi_arvalid, out_valid, done, error, m_axi_rready, cmd_ready} !== 6'b000000) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %b required 000000", {m_axi_arvalid, out_valid, done, error, m_axi_rready, cmd_ready});
        end
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        base = arlog.size();
        send_cmd(32'h3000, 4);
        consume(1'b0, 200);
        vectors++;
        if (arlog.size() != base + 1 || arlog[base] !== {32'h3000, 8'd3} || error !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_recover: ars=%0d first=%h error=%b required 1 0000300003 0", arlog.size() - base, arlog[base], error);
        end
    endtask

    task automatic test_back_to_back();
        slv_rand = 1'b1;
        for (int c = 0; c < 6; c++) begin
            int          base = arlog.size();
            int          n = $urandom_range(1, 200);
            int          sum = 0;
            bit          ok = 1'b1;
            logic [31:0] a = {10'd0, 16'($urandom_range(0, 16'hFFFF)), 6'd0};
            logic [31:0] na = a;
            send_cmd(a, n);
            consume(1'b1, 8000);
            for (int i = base; i < arlog.size(); i++) begin
                if (arlog[i].addr !== na || int'(arlog[i].addr[11:6]) + int'(arlog[i].len) > 63) ok = 1'b0;
                na  += (32'(arlog[i].len) + 1) << 6;
                sum += int'(arlog[i].len) + 1;
            end
            vectors++;
            if (!ok || sum != n || error !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_cmd%0d: beats=%0d aligned_ok=%b error=%b required %0d 1 0", c, sum, ok, error, n);
            end
        end
        slv_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_credit();
        test_error();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
